// File: rtl/dual_stepper_pulser.sv
// Two-axis step/dir pulse generator: both motors step concurrently on a shared period.
// Optional `POSITION_TRACK_EN adds signed 16-bit absolute position outputs pos1/pos2.
module dual_stepper_pulser #(
  parameter int DIR_SETUP_CYCLES   = 3,
  parameter int PULSE_HIGH_CYCLES  = 4,
  parameter int STEP_PERIOD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] steps1,
  input  logic [7:0] steps2,
  input  logic       dir1,
  input  logic       dir2,
  input  logic       dataReady,
  output logic       step1,
  output logic       step2,
  output logic       dirOut1,
  output logic       dirOut2,
  output logic       stepperReady,
  output logic       moveDone
`ifdef POSITION_TRACK_EN
  ,
  output logic signed [15:0] pos1,
  output logic signed [15:0] pos2
`endif
);

  localparam int MAX_DP = (DIR_SETUP_CYCLES > STEP_PERIOD_CYCLES) ?
                          DIR_SETUP_CYCLES : STEP_PERIOD_CYCLES;
  localparam int CW = $clog2(MAX_DP) + 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HI_LAST    = CW'(PULSE_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LO_LAST    = CW'(STEP_PERIOD_CYCLES - PULSE_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      rem1_q, rem1_d;
  logic [7:0]      rem2_q, rem2_d;
  logic            dir1_q, dir1_d;
  logic            dir2_q, dir2_d;
  logic            step1_q, step1_d;
  logic            step2_q, step2_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  // NOTE: every signal gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    rem1_d  = rem1_q;
    rem2_d  = rem2_q;
    dir1_d  = dir1_q;
    dir2_d  = dir2_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // ready_q gates the load so the cycle right after reset never accepts a move.
        if (ready_q && dataReady) begin
          rem1_d  = steps1;
          rem2_d  = steps2;
          dir1_d  = dir1;
          dir2_d  = dir2;
          state_d = ((steps1 | steps2) == 8'd0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = PULSE_HI;
          cnt_d   = '0;
        end
      end
      PULSE_HI: begin
        if (cnt_q == HI_LAST) begin
          state_d = PULSE_LO;
          cnt_d   = '0;
          if (rem1_q != 8'd0) rem1_d = rem1_q - 8'd1;
          if (rem2_q != 8'd0) rem2_d = rem2_q - 8'd1;
        end
      end
      PULSE_LO: begin
        if (cnt_q == LO_LAST) begin
          state_d = ((rem1_q | rem2_q) != 8'd0) ? PULSE_HI : DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    step1_d = (state_d == PULSE_HI) && (rem1_d != 8'd0);
    step2_d = (state_d == PULSE_HI) && (rem2_d != 8'd0);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem1_q  <= 8'd0;
      rem2_q  <= 8'd0;
      dir1_q  <= 1'b0;
      dir2_q  <= 1'b0;
      step1_q <= 1'b0;
      step2_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem1_q  <= rem1_d;
      rem2_q  <= rem2_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      step1_q <= step1_d;
      step2_q <= step2_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign step1        = step1_q;
  assign step2        = step2_q;
  assign dirOut1      = dir1_q;
  assign dirOut2      = dir2_q;
  assign stepperReady = ready_q;
  assign moveDone     = done_q;

`ifdef POSITION_TRACK_EN
  logic signed [15:0] pos1_q, pos2_q;

  // Position moves on the same edge the step output rises; wraps two's-complement.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos1_q <= 16'sd0;
      pos2_q <= 16'sd0;
    end else begin
      if (step1_d && !step1_q) pos1_q <= pos1_q + (dir1_q ? 16'sd1 : -16'sd1);
      if (step2_d && !step2_q) pos2_q <= pos2_q + (dir2_q ? 16'sd1 : -16'sd1);
    end
  end

  assign pos1 = pos1_q;
  assign pos2 = pos2_q;
`endif

endmodule
